// File: rtl/column_flattener_pkg.sv
// Shared types and screen geometry for the column flattener write-side stage.
package column_flattener_pkg;

    localparam int SCREEN_WIDTH  = 320;
    localparam int SCREEN_HEIGHT = 180;
    localparam int PIXEL_WIDTH   = 9;

    localparam logic [7:0] CEILING_COLOR = 8'h10;
    localparam logic [7:0] FLOOR_COLOR   = 8'h20;

    // Sized copies of the geometry so comparisons and sums stay width-matched.
    localparam logic [8:0]  COL_LIMIT  = 9'(SCREEN_WIDTH);
    localparam logic [7:0]  ROW_COUNT  = 8'(SCREEN_HEIGHT);
    localparam logic [7:0]  LAST_ROW   = 8'(SCREEN_HEIGHT - 1);
    localparam logic [15:0] ROW_STRIDE = 16'(SCREEN_WIDTH);

    typedef struct packed {
        logic       shade;
        logic [7:0] palette;
    } fb_pixel_t;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        DRAW      = 2'd1,
        SWAP_WAIT = 2'd2
    } state_t;

    // Pixel for one row: ceiling above the wall span, wall inside it, floor below.
    function automatic fb_pixel_t span_pixel(input logic [7:0] row,
                                             input logic [7:0] span_start,
                                             input logic [7:0] span_end,
                                             input logic       side,
                                             input logic [7:0] color);
        fb_pixel_t pix;
        if (row < span_start) begin
            pix = '{shade: 1'b0, palette: CEILING_COLOR};
        end else if (row < span_end) begin
            pix = '{shade: side, palette: color};
        end else begin
            pix = '{shade: 1'b0, palette: FLOOR_COLOR};
        end
        return pix;
    endfunction

endpackage

// File: rtl/column_flattener_if.sv
// Column descriptor handshake, frame-buffer swap status and pixel write bus.
interface column_flattener_if;
    import column_flattener_pkg::*;

    logic                   col_valid_in;
    logic                   col_ready_out;
    logic [8:0]             col_x_in;
    logic [7:0]             line_height_in;
    logic [7:0]             wall_color_in;
    logic                   side_in;
    logic [1:0]             fb_ready_to_switch_in;
    logic [15:0]            ray_address_out;
    logic [PIXEL_WIDTH-1:0] ray_pixel_out;
    logic                   ray_valid_out;
    logic                   ray_last_pixel_out;

    // Upstream ray caster / frame-buffer side.
    modport master (
        output col_valid_in, col_x_in, line_height_in, wall_color_in, side_in,
               fb_ready_to_switch_in,
        input  col_ready_out, ray_address_out, ray_pixel_out, ray_valid_out,
               ray_last_pixel_out
    );

    // The flattener itself.
    modport slave (
        input  col_valid_in, col_x_in, line_height_in, wall_color_in, side_in,
               fb_ready_to_switch_in,
        output col_ready_out, ray_address_out, ray_pixel_out, ray_valid_out,
               ray_last_pixel_out
    );

endinterface

// File: rtl/column_flattener_span.sv
// Combinational wall span: clamps the line height to the screen and centres it.
module column_span_calc
    import column_flattener_pkg::*;
(
    input  logic [7:0] line_height,
    output logic [7:0] span_start,
    output logic [7:0] span_end
);

    logic [7:0] clamped;

    // Clamp, then centre the span; the end is exclusive and never exceeds ROW_COUNT.
    always_comb begin
        clamped    = (line_height > ROW_COUNT) ? ROW_COUNT : line_height;
        span_start = (ROW_COUNT - clamped) >> 1;
        span_end   = span_start + clamped;
    end

endmodule

// File: rtl/column_flattener.sv
// Sweeps one wall-column descriptor top-to-bottom into flat frame-buffer writes,
// flags the final pixel of a frame and stalls until the buffers swap.
module column_flattener
    import column_flattener_pkg::*;
(
    input  logic         pixel_clk_in,
    input  logic         rst_in,
    column_flattener_if.slave bus
);

    state_t     state, next_state;
    logic       accept, emit, clear_count, ready;

    logic [7:0] in_start, in_end;
    logic [7:0] span_start_q, span_end_q, wall_color_q;
    logic       side_q;

    logic [7:0]  row_q;
    logic [7:0]  next_row;
    logic [15:0] addr_q;
    fb_pixel_t   pixel_q;
    logic        valid_q, last_q;
    logic [8:0]  col_count_q;

    column_span_calc u_span (
        .line_height (bus.line_height_in),
        .span_start  (in_start),
        .span_end    (in_end)
    );

    assign next_row = row_q + 8'd1;

    // State register.
    always_ff @(posedge pixel_clk_in) begin
        if (rst_in) state <= IDLE;
        else        state <= next_state;
    end

    // Next-state and control strobes for the datapath.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves one unassigned and infers a latch.
        next_state  = state;
        ready       = 1'b0;
        accept      = 1'b0;
        emit        = 1'b0;
        clear_count = 1'b0;
        unique case (state)
            IDLE: begin
                ready = 1'b1;
                if (bus.col_valid_in && (bus.col_x_in < COL_LIMIT)) begin
                    accept     = 1'b1;
                    next_state = DRAW;
                end
            end
            DRAW: begin
                if (row_q == LAST_ROW) begin
                    next_state = (col_count_q == COL_LIMIT) ? SWAP_WAIT : IDLE;
                end else begin
                    emit = 1'b1;
                end
            end
            SWAP_WAIT: begin
                if (bus.fb_ready_to_switch_in == 2'b11) begin
                    clear_count = 1'b1;
                    next_state  = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Descriptor capture at acceptance; only read while drawing.
    always_ff @(posedge pixel_clk_in) begin
        // NOTE: pure data registers qualified by the FSM need no reset; leaving it off keeps them plain enables.
        if (accept) begin
            span_start_q <= in_start;
            span_end_q   <= in_end;
            wall_color_q <= bus.wall_color_in;
            side_q       <= bus.side_in;
        end
    end

    // Registered pixel stream: row 0 on acceptance, then one row per cycle;
    // address and pixel hold when nothing new is emitted.
    always_ff @(posedge pixel_clk_in) begin
        if (rst_in) begin
            row_q       <= '0;
            addr_q      <= '0;
            pixel_q     <= '0;
            valid_q     <= 1'b0;
            last_q      <= 1'b0;
            col_count_q <= '0;
        end else begin
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            if (accept) begin
                row_q   <= '0;
                addr_q  <= {7'd0, bus.col_x_in};
                pixel_q <= span_pixel(8'd0, in_start, in_end, bus.side_in, bus.wall_color_in);
                valid_q <= 1'b1;
            end
            if (emit) begin
                row_q   <= next_row;
                addr_q  <= addr_q + ROW_STRIDE;
                pixel_q <= span_pixel(next_row, span_start_q, span_end_q, side_q, wall_color_q);
                valid_q <= 1'b1;
                if (next_row == LAST_ROW) begin
                    col_count_q <= col_count_q + 9'd1;
                    last_q      <= ((col_count_q + 9'd1) == COL_LIMIT);
                end
            end
            if (clear_count) begin
                col_count_q <= '0;
            end
        end
    end

    assign bus.col_ready_out      = ready;
    assign bus.ray_address_out    = addr_q;
    assign bus.ray_pixel_out      = pixel_q;
    assign bus.ray_valid_out      = valid_q;
    assign bus.ray_last_pixel_out = last_q;

endmodule

// File: tb/tb_column_flattener.sv
// Scoreboard bench for column_flattener: stimulus pushes the modelled pixel
// stream per column, an independent monitor pops and compares on every valid.
module tb_column_flattener;
    import column_flattener_pkg::*;

    logic pixel_clk_in = 1'b0;
    logic rst_in       = 1'b1;

    column_flattener_if bus ();

    column_flattener dut (
        .pixel_clk_in (pixel_clk_in),
        .rst_in       (rst_in),
        .bus          (bus)
    );

    always #5 pixel_clk_in = ~pixel_clk_in;

    typedef struct {
        logic [15:0] addr;
        logic [8:0]  pix;
        logic        last;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        mon_e;
    int          errors      = 0;
    int          checks      = 0;
    int          model_count = 0;
    int          last_pulses = 0;
    bit          mon_en      = 1'b0;
    logic [15:0] held_addr   = '0;
    logic [8:0]  held_pix    = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, want, $time);
        end
    endtask

    // Reference model: the whole column as the rules describe it.
    task automatic push_column(input int x, input int lh, input logic [7:0] color, input logic side);
        int   lhc;
        int   start;
        exp_t e;
        if (x >= SCREEN_WIDTH) return;
        lhc   = (lh > SCREEN_HEIGHT) ? SCREEN_HEIGHT : lh;
        start = (SCREEN_HEIGHT - lhc) / 2;
        model_count++;
        for (int r = 0; r < SCREEN_HEIGHT; r++) begin
            e.addr = 16'(x + SCREEN_WIDTH * r);
            if (r < start)             e.pix = {1'b0, CEILING_COLOR};
            else if (r < start + lhc)  e.pix = {side, color};
            else                       e.pix = {1'b0, FLOOR_COLOR};
            e.last = (r == SCREEN_HEIGHT - 1) && (model_count == SCREEN_WIDTH);
            exp_q.push_back(e);
        end
    endtask

    // Monitor: compare every presented pixel; idle cycles must hold the bus.
    always @(negedge pixel_clk_in) begin
        if (mon_en) begin
            if (bus.ray_last_pixel_out) last_pulses++;
            if (bus.ray_valid_out) begin
                check("ready_low_while_drawing", 32'(bus.col_ready_out), 32'd0);
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_pixel: got addr %0d pixel 0x%0h, expected no pixel",
                             bus.ray_address_out, bus.ray_pixel_out);
                    held_addr = bus.ray_address_out;
                    held_pix  = bus.ray_pixel_out;
                end else begin
                    mon_e = exp_q.pop_front();
                    check("pixel_addr", 32'(bus.ray_address_out), 32'(mon_e.addr));
                    check("pixel_data", 32'(bus.ray_pixel_out), 32'(mon_e.pix));
                    check("last_pixel", 32'(bus.ray_last_pixel_out), 32'(mon_e.last));
                    held_addr = mon_e.addr;
                    held_pix  = mon_e.pix;
                end
            end else begin
                check("hold_addr", 32'(bus.ray_address_out), 32'(held_addr));
                check("hold_pixel", 32'(bus.ray_pixel_out), 32'(held_pix));
                check("no_last_when_idle", 32'(bus.ray_last_pixel_out), 32'd0);
            end
        end
    end

    // Offer a descriptor, wait (bounded) for acceptance, then model it.
    task automatic send_column(input int x, input int lh, input logic [7:0] color, input logic side);
        int waited = 0;
        bus.col_valid_in   = 1'b1;
        bus.col_x_in       = 9'(x);
        bus.line_height_in = 8'(lh);
        bus.wall_color_in  = color;
        bus.side_in        = side;
        @(negedge pixel_clk_in);
        while (!bus.col_ready_out && waited < 1000) begin
            waited++;
            @(negedge pixel_clk_in);
        end
        if (!bus.col_ready_out) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: ready still 0 after %0d cycles, expected 1", waited);
            bus.col_valid_in = 1'b0;
            return;
        end
        @(posedge pixel_clk_in);
        #1;
        bus.col_valid_in = 1'b0;
        push_column(x, lh, color, side);
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 5000) begin
            @(posedge pixel_clk_in);
            n++;
        end
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: %0d pixels outstanding, expected 0", exp_q.size());
            exp_q.delete();
        end
        repeat (3) @(posedge pixel_clk_in);
        #1;
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.col_valid_in          = 1'b0;
        bus.col_x_in              = '0;
        bus.line_height_in        = '0;
        bus.wall_color_in         = '0;
        bus.side_in               = 1'b0;
        bus.fb_ready_to_switch_in = 2'b00;
        repeat (3) @(posedge pixel_clk_in);
        #1;
        rst_in = 1'b0;
        mon_en = 1'b1;

        // Idle after reset: ready high, bus quiet at zero.
        for (int i = 0; i < 100; i++) begin
            @(negedge pixel_clk_in);
            check("reset_ready", 32'(bus.col_ready_out), 32'd1);
        end
        @(posedge pixel_clk_in);
        #1;

        // Basic column with a centred 100-row wall.
        send_column(5, 100, 8'h33, 1'b1);
        drain();

        // Height boundaries and edge columns, then a few random ones.
        send_column(17, 0, 8'h44, 1'b0);
        send_column(300, 255, 8'h55, 1'b1);
        send_column(319, 180, 8'h66, 1'b0);
        send_column(2, 179, 8'h77, 1'b1);
        for (int i = 0; i < 3; i++) begin
            send_column(int'($urandom_range(0, 319)), int'($urandom_range(0, 255)),
                        8'($urandom), 1'($urandom));
        end
        drain();

        // Out-of-range column is taken but dropped.
        send_column(400, 90, 8'h99, 1'b1);
        @(negedge pixel_clk_in);
        check("drop_ready", 32'(bus.col_ready_out), 32'd1);
        check("drop_no_valid", 32'(bus.ray_valid_out), 32'd0);
        @(posedge pixel_clk_in);
        #1;

        // Reset in the middle of a column.
        send_column(9, 120, 8'hab, 1'b0);
        repeat (60) @(posedge pixel_clk_in);
        #1;
        rst_in = 1'b1;
        @(posedge pixel_clk_in);
        #1;
        exp_q.delete();
        held_addr   = '0;
        held_pix    = '0;
        model_count = 0;
        rst_in      = 1'b0;
        @(negedge pixel_clk_in);
        check("post_reset_ready", 32'(bus.col_ready_out), 32'd1);
        check("post_reset_valid", 32'(bus.ray_valid_out), 32'd0);
        @(posedge pixel_clk_in);
        #1;

        // Full frame in reverse column order; last pixel lands on x=0, row 179.
        last_pulses = 0;
        for (int x = SCREEN_WIDTH - 1; x >= 0; x--) begin
            send_column(x, int'($urandom_range(0, 255)), 8'($urandom), 1'($urandom));
        end
        drain();
        check("frame_last_pulses", 32'(last_pulses), 32'd1);
        check("frame_last_addr", 32'(held_addr), 32'd57280);

        // Stall until both buffers report done.
        for (int i = 0; i < 20; i++) begin
            bus.fb_ready_to_switch_in = 2'($urandom_range(0, 2));
            @(negedge pixel_clk_in);
            check("swap_wait_ready", 32'(bus.col_ready_out), 32'd0);
            check("swap_wait_valid", 32'(bus.ray_valid_out), 32'd0);
            @(posedge pixel_clk_in);
            #1;
        end
        bus.fb_ready_to_switch_in = 2'b11;
        @(negedge pixel_clk_in);
        check("swap_same_cycle_ready", 32'(bus.col_ready_out), 32'd0);
        @(posedge pixel_clk_in);
        #1;
        bus.fb_ready_to_switch_in = 2'b00;
        model_count = 0;
        @(negedge pixel_clk_in);
        check("swap_next_cycle_ready", 32'(bus.col_ready_out), 32'd1);
        @(posedge pixel_clk_in);
        #1;

        // First column of the next frame must not be flagged last.
        send_column(7, 50, 8'h5a, 1'b0);
        drain();
        check("next_frame_no_last", 32'(last_pulses), 32'd1);

        mon_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
